// File: rtl/phy_rx_serial_paralelo.sv
// Receive side of one PHY lane: finds byte alignment on COMMA, locks after BC_LOCK
// consecutive aligned commas, then delivers each non-COMMA byte with a valid flag.
module phy_rx_serial_paralelo #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  COMMA   = WIDTH'(8'hBC),
  parameter int                BC_LOCK = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BCW  = $clog2(BC_LOCK + 1);
  localparam logic [CNTW-1:0] LAST_BIT  = CNTW'(WIDTH - 1);
  localparam logic [BCW-1:0]  BC_LOCK_V = BCW'(BC_LOCK);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]    bc_cnt_q, bc_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              active_q, active_d;

  logic [WIDTH-1:0]  nxt;
  logic              is_comma;
  logic              boundary;
  logic [BCW-1:0]    bc_inc;

  // All decisions use the register value that includes the bit sampled at this edge.
  assign nxt      = {shreg_q[WIDTH-2:0], serial_in};
  assign is_comma = (nxt == COMMA);
  assign boundary = (state_q != SEARCH) && (bit_cnt_q == LAST_BIT);
  assign bc_inc   = bc_cnt_q + 1'b1;

  always_comb begin
    shreg_d   = nxt;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = boundary;
    active_d  = active_q;
    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_comma) begin
          bc_cnt_d = BCW'(1);
          if (BC_LOCK == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d  = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_LOCK_V) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // Misaligned or junk symbol: drop the partial lock and slide again.
            state_d   = SEARCH;
            bc_cnt_d  = '0;
            bit_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = SEARCH;
        bit_cnt_d = '0;
        bc_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for phy_rx_serial_paralelo: reset, comma lock, data delivery,
// lock loss in ALIGN, and reset while ACTIVE.
module tb_phy_rx_serial_paralelo;

  logic       clk_8f;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_vec = 0;
  int n_err = 0;

  phy_rx_serial_paralelo dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data"},   32'(data_out),    32'h0);
    chk({tag, ".valid"},  32'(valid_out),   32'h0);
    chk({tag, ".strobe"}, 32'(byte_strobe), 32'h0);
    chk({tag, ".active"}, 32'(active),      32'h0);
  endtask

  // One bit, no boundary expected; checks strobe and lock status after the edge.
  task automatic send_bit(input logic b, input logic exp_active, input string tag);
    @(negedge clk_8f);
    serial_in = b;
    @(posedge clk_8f);
    #1;
    chk({tag, ".strobe"}, 32'(byte_strobe), 32'h0);
    chk({tag, ".active"}, 32'(active), 32'(exp_active));
  endtask

  // One byte MSB first. Before the LSB the outputs must hold the given values;
  // strobe is expected only at the LSB edge and only if strobe_lsb is set.
  task automatic send_byte(input logic [7:0] b, input logic strobe_lsb,
                           input logic [7:0] hold_d, input logic hold_v,
                           input logic hold_a, input string tag);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_8f);
      serial_in = b[i];
      @(posedge clk_8f);
      #1;
      if (i == 0) begin
        chk({tag, ".strobe_lsb"}, 32'(byte_strobe), 32'(strobe_lsb));
      end else begin
        chk({tag, ".strobe"}, 32'(byte_strobe), 32'h0);
        chk({tag, ".hold_data"}, 32'(data_out), 32'(hold_d));
        chk({tag, ".hold_valid"}, 32'(valid_out), 32'(hold_v));
        chk({tag, ".hold_active"}, 32'(active), 32'(hold_a));
      end
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"},   32'(data_out),  32'(d));
    chk({tag, ".valid"},  32'(valid_out), 32'(v));
    chk({tag, ".active"}, 32'(active),    32'(a));
  endtask

  initial begin
    reset     = 1'b0;
    serial_in = 1'b0;

    // Held in reset with a toggling input: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_8f);
      serial_in = i[0];
      @(posedge clk_8f);
      #1;
      chk_all_zero("rst_hold");
    end
    @(negedge clk_8f);
    reset     = 1'b1;
    serial_in = 1'b0;

    // Three junk bits, then four commas; first found by sliding search (no strobe).
    send_bit(1'b0, 1'b0, "junk0");
    send_bit(1'b0, 1'b0, "junk1");
    send_bit(1'b0, 1'b0, "junk2");
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, "bc1");
    chk_out("bc1_end", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "bc2");
    chk_out("bc2_end", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "bc3");
    chk_out("bc3_end", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "bc4");
    chk_out("bc4_lock", 8'h00, 1'b0, 1'b1);

    // Locked data stream, each value held for the whole next byte.
    send_byte(8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, "dFF");
    chk_out("dFF_end", 8'hFF, 1'b1, 1'b1);
    send_byte(8'hEE, 1'b1, 8'hFF, 1'b1, 1'b1, "dEE");
    chk_out("dEE_end", 8'hEE, 1'b1, 1'b1);
    send_byte(8'hDD, 1'b1, 8'hEE, 1'b1, 1'b1, "dDD");
    chk_out("dDD_end", 8'hDD, 1'b1, 1'b1);
    send_byte(8'hCC, 1'b1, 8'hDD, 1'b1, 1'b1, "dCC");
    chk_out("dCC_end", 8'hCC, 1'b1, 1'b1);

    // A comma in the data stream clears valid but keeps the last byte.
    send_byte(8'hBB, 1'b1, 8'hCC, 1'b1, 1'b1, "dBB");
    chk_out("dBB_end", 8'hBB, 1'b1, 1'b1);
    send_byte(8'hBC, 1'b1, 8'hBB, 1'b1, 1'b1, "dBC");
    chk_out("dBC_end", 8'hBB, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b1, 8'hBB, 1'b0, 1'b1, "dAA");
    chk_out("dAA_end", 8'hAA, 1'b1, 1'b1);

    // Reset asserted mid-byte, between clock edges: outputs clear at once.
    send_bit(1'b0, 1'b1, "mid0");
    send_bit(1'b1, 1'b1, "mid1");
    send_bit(1'b0, 1'b1, "mid2");
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) begin
      @(posedge clk_8f);
      #1;
      chk_all_zero("rst_mid_hold");
    end
    @(negedge clk_8f);
    reset = 1'b1;

    // Two aligned commas then a data byte drops back to search.
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, "r_bc1");
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "r_bc2");
    send_byte(8'h32, 1'b1, 8'h00, 1'b0, 1'b0, "r_32");
    chk_out("r_32_end", 8'h00, 1'b0, 1'b0);

    // Fresh search: three commas do not lock, the fourth does.
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, "f_bc1");
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "f_bc2");
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "f_bc3");
    chk_out("f_bc3_end", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0, 1'b0, "f_bc4");
    chk_out("f_bc4_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, "f_d5A");
    chk_out("f_d5A_end", 8'h5A, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
